// File: rtl/encode_pack_if.sv
// Purpose: code-in / packed-word-out bundle between encode_ctl, encode_pack and the destination FIFO.
// Latency: none, wires only; optional m_dst_bits present when ENCODE_PACK_CNT_EN is defined.
// Backpressure: code_ready toward the producer, fo_full from the destination FIFO.
interface encode_pack_if #(
  parameter int OUT_W  = 64,
  parameter int CODE_W = 13,
  parameter int LEN_W  = 4
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic [LEN_W-1:0]  code_len;
  logic              code_finish;
  logic              fo_full;
  logic              m_dst_putn;
  logic [OUT_W-1:0]  m_dst;
  logic              m_dst_last;
  logic              m_endn;
`ifdef ENCODE_PACK_CNT_EN
  logic [31:0]       m_dst_bits;

  // environment side: code producer and destination FIFO / DMA
  modport master (
    output code_valid, code, code_len, code_finish, fo_full,
    input  code_ready, m_dst_putn, m_dst, m_dst_last, m_endn, m_dst_bits
  );

  // packer side
  modport slave (
    input  code_valid, code, code_len, code_finish, fo_full,
    output code_ready, m_dst_putn, m_dst, m_dst_last, m_endn, m_dst_bits
  );
`else
  // environment side: code producer and destination FIFO / DMA
  modport master (
    output code_valid, code, code_len, code_finish, fo_full,
    input  code_ready, m_dst_putn, m_dst, m_dst_last, m_endn
  );

  // packer side
  modport slave (
    input  code_valid, code, code_len, code_finish, fo_full,
    output code_ready, m_dst_putn, m_dst, m_dst_last, m_endn
  );
`endif
endinterface

// File: rtl/encode_pack.sv
// Purpose: packs (code, length) pairs MSB-first into OUT_W-bit words; flush with zero padding, last/end strobes.
// Latency: word strobed one cycle after the accept that fills OUT_W bits; m_endn one cycle after the last word.
// Backpressure: fo_full stalls emits; code_ready drops once a full word is pending. ENCODE_PACK_CNT_EN adds m_dst_bits.
module encode_pack #(
  parameter int OUT_W  = 64,
  parameter int CODE_W = 13,
  parameter int LEN_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  encode_pack_if.slave    bus
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_W_F  = FILL_W'(ACC_W);
  localparam logic [LEN_W-1:0]  CODE_W_L = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q;
  logic [FILL_W-1:0]   fill_q;
  logic                putn_q;
  logic                endn_q;
  logic                last_q;
  logic [OUT_W-1:0]    dst_q;

  logic                ready;
  logic                accept;
  logic                emit;
  logic                emit_last;
  logic [LEN_W-1:0]    len_sat;
  logic [FILL_W-1:0]   shamt;
  logic [ACC_W-1:0]    code_ext;
  logic [ACC_W-1:0]    len_mask;
  logic [ACC_W-1:0]    acc_ins;

  // Valid bits sit left-justified in acc_q; a new code lands directly below them.
  always_comb begin
    len_sat  = (bus.code_len > CODE_W_L) ? CODE_W_L : bus.code_len;
    code_ext = ACC_W'(bus.code);
    len_mask = ~({ACC_W{1'b1}} << len_sat);
    shamt    = ACC_W_F - fill_q - FILL_W'(len_sat);
    acc_ins  = (code_ext & len_mask) << shamt;
  end

  // Handshake, emit decision and next state; accept and emit never coincide since ready needs fill<OUT_W.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    ready     = ce && (state_q == ST_RUN) && (fill_q < OUT_W_F) && !rst;
    accept    = ready && bus.code_valid;
    case (state_q)
      ST_RUN: begin
        if (ce && (fill_q >= OUT_W_F) && !bus.fo_full) begin
          emit = 1'b1;
        end
        if (accept && bus.code_finish) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Any fill level is emitted here; a word that drains the accumulator is the last one.
        if (ce && !bus.fo_full) begin
          emit = 1'b1;
          if (fill_q <= OUT_W_F) begin
            emit_last = 1'b1;
            state_d   = ST_END;
          end
        end
      end
      ST_END: begin
        if (ce) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, fill count and output strobes; strobes fall back high on every edge without an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
      putn_q <= 1'b1;
      endn_q <= 1'b1;
      last_q <= 1'b0;
      dst_q  <= '0;
    end else begin
      putn_q <= 1'b1;
      endn_q <= 1'b1;
      last_q <= 1'b0;
      if (accept) begin
        acc_q  <= acc_q | acc_ins;
        fill_q <= fill_q + FILL_W'(len_sat);
      end
      if (emit) begin
        dst_q  <= acc_q[ACC_W-1 -: OUT_W];
        putn_q <= 1'b0;
        last_q <= emit_last;
        acc_q  <= acc_q << OUT_W;
        fill_q <= emit_last ? '0 : (fill_q - OUT_W_F);
      end
      if (ce && (state_q == ST_END)) begin
        endn_q <= 1'b0;
        fill_q <= '0;
      end
    end
  end

  assign bus.code_ready = ready;
  assign bus.m_dst_putn = putn_q;
  assign bus.m_dst      = dst_q;
  assign bus.m_dst_last = last_q;
  assign bus.m_endn     = endn_q;

`ifdef ENCODE_PACK_CNT_EN
  logic [31:0] bits_q;
  logic        bits_clr_q;

  // Payload bit counter: frozen after END until the next stream's first accept restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q     <= '0;
      bits_clr_q <= 1'b0;
    end else begin
      if (ce && (state_q == ST_END)) begin
        bits_clr_q <= 1'b1;
      end
      if (accept) begin
        bits_q     <= (bits_clr_q ? 32'd0 : bits_q) + 32'(len_sat);
        bits_clr_q <= 1'b0;
      end
    end
  end

  assign bus.m_dst_bits = bits_q;
`endif

endmodule

// File: tb/tb_encode_pack.sv
// Purpose: directed self-checking bench for encode_pack (reset, packing, straddle, flush, backpressure, ce).
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after the following posedge.
// Backpressure: fo_full driven directly by the stimulus.
module tb_encode_pack;
  localparam int OUT_W  = 64;
  localparam int CODE_W = 13;
  localparam int LEN_W  = 4;

  logic clk;
  logic rst;
  logic ce;
  int   checks;
  int   errors;

  encode_pack_if #(.OUT_W(OUT_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) bus_i ();

  encode_pack #(.OUT_W(OUT_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [CODE_W-1:0] c,
                       input logic [LEN_W-1:0] l, input logic fin);
    bus_i.code_valid  = vld;
    bus_i.code        = c;
    bus_i.code_len    = l;
    bus_i.code_finish = fin;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CODE_W'(8'h55 + i), 4'd8, 1'b0);
      tick();
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_i.m_dst_putn !== 1'b1 || bus_i.m_endn !== 1'b1 || bus_i.m_dst_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobes: putn=%b endn=%b last=%b want 1 1 0",
                 bus_i.m_dst_putn, bus_i.m_endn, bus_i.m_dst_last);
      end
      checks++;
      if (bus_i.m_dst !== 64'h0) begin
        errors++;
        $display("FAIL reset_dst: got %h want 0", bus_i.m_dst);
      end
      checks++;
      if (bus_i.code_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b want 0", bus_i.code_ready);
      end
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (bus_i.code_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %b want 1", bus_i.code_ready);
    end
  endtask

  task automatic test_eight;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CODE_W'(i), 4'd8, 1'b0);
      checks++;
      if (bus_i.code_ready !== 1'b1) begin
        errors++;
        $display("FAIL eight_ready_%0d: got %b want 1", i, bus_i.code_ready);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (bus_i.m_dst_putn !== 1'b1 || bus_i.code_ready !== 1'b0) begin
      errors++;
      $display("FAIL eight_pending: putn=%b ready=%b want 1 0", bus_i.m_dst_putn, bus_i.code_ready);
    end
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'h0102030405060708 || bus_i.m_dst_last !== 1'b0) begin
      errors++;
      $display("FAIL eight_word: putn=%b dst=%h last=%b want 0 0102030405060708 0",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b1 || bus_i.m_endn !== 1'b1) begin
      errors++;
      $display("FAIL eight_after: putn=%b endn=%b want 1 1", bus_i.m_dst_putn, bus_i.m_endn);
    end
  endtask

  task automatic test_straddle;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 13'hF, 4'd4, 1'b0);
      tick();
    end
    drive(1'b1, 13'h1A5, 4'd9, 1'b0);
    checks++;
    if (bus_i.code_ready !== 1'b1) begin
      errors++;
      $display("FAIL straddle_ready: got %b want 1", bus_i.code_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'hFFFFFFFFFFFFFFFD || bus_i.m_dst_last !== 1'b0) begin
      errors++;
      $display("FAIL straddle_word1: putn=%b dst=%h last=%b want 0 fffffffffffffffd 0",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    drive(1'b1, '0, 4'd0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'h2800000000000000 || bus_i.m_dst_last !== 1'b1) begin
      errors++;
      $display("FAIL straddle_word2: putn=%b dst=%h last=%b want 0 2800000000000000 1",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    tick();
    checks++;
    if (bus_i.m_endn !== 1'b0 || bus_i.m_dst_putn !== 1'b1) begin
      errors++;
      $display("FAIL straddle_end: endn=%b putn=%b want 0 1", bus_i.m_endn, bus_i.m_dst_putn);
    end
    tick();
  endtask

  task automatic test_partial;
    drive(1'b1, 13'hA, 4'd4, 1'b0);
    tick();
    drive(1'b1, 13'hB, 4'd4, 1'b0);
    tick();
    drive(1'b1, 13'hC, 4'd4, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (bus_i.m_dst_putn !== 1'b1 || bus_i.m_endn !== 1'b1) begin
      errors++;
      $display("FAIL partial_idle: putn=%b endn=%b want 1 1", bus_i.m_dst_putn, bus_i.m_endn);
    end
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'hABC0000000000000 ||
        bus_i.m_dst_last !== 1'b1 || bus_i.m_endn !== 1'b1) begin
      errors++;
      $display("FAIL partial_word: putn=%b dst=%h last=%b endn=%b want 0 abc0000000000000 1 1",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last, bus_i.m_endn);
    end
    tick();
    checks++;
    if (bus_i.m_endn !== 1'b0 || bus_i.m_dst_putn !== 1'b1 || bus_i.m_dst_last !== 1'b0) begin
      errors++;
      $display("FAIL partial_end: endn=%b putn=%b last=%b want 0 1 0",
               bus_i.m_endn, bus_i.m_dst_putn, bus_i.m_dst_last);
    end
`ifdef ENCODE_PACK_CNT_EN
    checks++;
    if (bus_i.m_dst_bits !== 32'd12) begin
      errors++;
      $display("FAIL partial_bits: got %0d want 12", bus_i.m_dst_bits);
    end
`endif
    tick();
    checks++;
    if (bus_i.m_endn !== 1'b1) begin
      errors++;
      $display("FAIL partial_end_pulse: endn=%b want 1", bus_i.m_endn);
    end
`ifdef ENCODE_PACK_CNT_EN
    checks++;
    if (bus_i.m_dst_bits !== 32'd12) begin
      errors++;
      $display("FAIL partial_bits_hold: got %0d want 12", bus_i.m_dst_bits);
    end
`endif
  endtask

  task automatic test_mask_sat;
    drive(1'b1, 13'h1FFF, 4'd4, 1'b0);
    tick();
    drive(1'b1, 13'h0ABC, 4'd15, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'hF55E000000000000 || bus_i.m_dst_last !== 1'b1) begin
      errors++;
      $display("FAIL mask_sat_word: putn=%b dst=%h last=%b want 0 f55e000000000000 1",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CODE_W'(8'hA0 + i), 4'd8, 1'b0);
      tick();
    end
    bus_i.fo_full = 1'b1;
    drive(1'b1, 13'h77, 4'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_i.m_dst_putn !== 1'b1 || bus_i.code_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: putn=%b ready=%b want 1 0", i, bus_i.m_dst_putn, bus_i.code_ready);
      end
    end
    bus_i.fo_full = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'hA0A1A2A3A4A5A6A7) begin
      errors++;
      $display("FAIL bp_word: putn=%b dst=%h want 0 a0a1a2a3a4a5a6a7", bus_i.m_dst_putn, bus_i.m_dst);
    end
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b1 || bus_i.code_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_single: putn=%b ready=%b want 1 1", bus_i.m_dst_putn, bus_i.code_ready);
    end
  endtask

  task automatic test_empty_finish_ce;
    drive(1'b1, 13'h1234, 4'd0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'h0 || bus_i.m_dst_last !== 1'b1) begin
      errors++;
      $display("FAIL empty_word: putn=%b dst=%h last=%b want 0 0 1",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    tick();
    checks++;
    if (bus_i.m_endn !== 1'b0 || bus_i.m_dst_putn !== 1'b1) begin
      errors++;
      $display("FAIL empty_end: endn=%b putn=%b want 0 1", bus_i.m_endn, bus_i.m_dst_putn);
    end
    tick();
    // same sequence, frozen for three cycles after the finish is accepted
    drive(1'b1, 13'h0, 4'd0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_i.m_dst_putn !== 1'b1 || bus_i.m_endn !== 1'b1) begin
        errors++;
        $display("FAIL ce_freeze_%0d: putn=%b endn=%b want 1 1", i, bus_i.m_dst_putn, bus_i.m_endn);
      end
    end
    ce = 1'b1;
    tick();
    checks++;
    if (bus_i.m_dst_putn !== 1'b0 || bus_i.m_dst !== 64'h0 || bus_i.m_dst_last !== 1'b1) begin
      errors++;
      $display("FAIL ce_word: putn=%b dst=%h last=%b want 0 0 1",
               bus_i.m_dst_putn, bus_i.m_dst, bus_i.m_dst_last);
    end
    tick();
    checks++;
    if (bus_i.m_endn !== 1'b0) begin
      errors++;
      $display("FAIL ce_end: endn=%b want 0", bus_i.m_endn);
    end
    tick();
    ce = 1'b0;
    #1;
    checks++;
    if (bus_i.code_ready !== 1'b0) begin
      errors++;
      $display("FAIL ce_ready: got %b want 0", bus_i.code_ready);
    end
    ce = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ce     = 1'b1;
    bus_i.fo_full = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_eight();
    test_straddle();
    test_partial();
    test_mask_sat();
    test_backpressure();
    test_empty_finish_ce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encode_pack.md
Name: encode_pack

Overview:
- Parametrised variable-length code packer; next generation of the encoder output stage.
- Accepts (code, length) pairs from the match/control stage and packs them MSB-first into OUT_W-bit destination words.
- Handles destination-FIFO backpressure, final-word flush with zero padding, and last/end signalling to the DMA side.
- Sits between encode_ctl and the destination FIFO, replacing the fixed 64/13-bit output stage.

Parameters:
OUT_W, 64, destination word width in bits (multiple of 8, >= 16).
CODE_W, 13, maximum code width in bits (<= OUT_W).
LEN_W, 4, width of code_len; 2^LEN_W-1 >= CODE_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; low = freeze
code_valid  in  1  code present
code_ready  out  1  packer accepts code this cycle
code  in  CODE_W  code bits, right-justified
code_len  in  LEN_W  valid bits in code, 0..CODE_W
code_finish  in  1  qualifies accepted code as final; flush after it
fo_full  in  1  destination FIFO full
m_dst_putn  out  1  active-low word strobe
m_dst  out  OUT_W  packed word
m_dst_last  out  1  word is the final word of the stream; valid with putn low
m_endn  out  1  active-low end-of-stream pulse

Behaviour:
- Single clock clk; rst is synchronous, active-high.
- Reset values: m_dst_putn=1, m_endn=1, m_dst=0, m_dst_last=0, accumulator=0, fill=0, state=RUN. code_ready=0 while rst is high.
- Accumulator: OUT_W+CODE_W bits. fill counts valid bits, range 0..OUT_W+CODE_W-1.
- Handshake:
  - code_ready = ce & state==RUN & fill<OUT_W & !rst (combinational).
  - A code is accepted on an edge with code_valid & code_ready.
  - Only the low code_len bits are used; upper bits are masked. code_len>CODE_W saturates to CODE_W. code_len=0 is a no-op, but its code_finish is still honoured.
  - The code is appended directly below existing bits; fill += len.
- Emit:
  - On an edge with ce & fill>=OUT_W & !fo_full, register m_dst = top OUT_W bits, drive m_dst_putn=0 for one cycle, shift the accumulator left by OUT_W, and set fill -= OUT_W.
  - No accept occurs in the same cycle, because ready requires fill<OUT_W.
  - Minimum latency: word visible one cycle after the accepting edge that crosses OUT_W.
- Backpressure: while fo_full=1, no emit occurs, putn stays high, and ready stays low once fill>=OUT_W. No data is lost or duplicated.
- States:
  - RUN: normal operation. An accept with code_finish moves to FLUSH.
  - FLUSH: full words are emitted as in RUN.
    - A word whose emission leaves fill=0 carries m_dst_last=1.
    - When 0<fill<OUT_W, emit one final word: remaining bits left-justified, zero-padded at LSBs, m_dst_last=1.
    - If fill=0 on FLUSH entry, emit one all-zero word with m_dst_last=1.
    - All emits in FLUSH honour fo_full. After the last-word emit, go to END.
  - END: m_endn=0 for one cycle, the cycle after the last-word strobe. Clear fill, return to RUN.
- Strobes: m_dst_putn and m_endn deassert (high) on every edge without their event. m_dst holds its last value. m_dst_last returns to 0 with putn.
- ce=0: no state, fill, or accumulator change; no handshake; strobes deassert on the next edge.
- Reset mid-operation: partial accumulator is discarded; no last/end is produced.

Optional Feature:
ENCODE_PACK_CNT_EN
- Defined: adds output m_dst_bits [31:0], counting total payload bits accepted (sum of code_len, excluding padding).
  - Cleared by rst and by the first accept after END.
  - Stable from the m_endn pulse until that next accept.
  - Wraps at 2^32.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset: assert rst 3 cycles mid-stream -> m_dst_putn=1, m_endn=1, m_dst_last=0, m_dst=0, code_ready=0 during rst and =1 the cycle after (ce=1).
- Eight codes len 8, values 0x01..0x08, back-to-back -> one putn pulse with m_dst=0x0102030405060708, m_dst_last=0, appearing the cycle after the 8th accept.
- Straddle: 15 codes len 4 value 0xF (fill 60), then len 9 value 0x1A5 -> m_dst=0xFFFFFFFFFFFFFFFD, residual fill 5 bits 00101; finish -> second word 0x2800000000000000 with last=1.
- Partial flush: codes len 4 0xA,0xB,0xC, the third with code_finish -> m_dst=0xABC0000000000000, m_dst_last=1, m_endn low exactly the next cycle; with CNT_EN, m_dst_bits=12.
- Backpressure: word pending, fo_full=1 for 5 cycles -> putn high and code_ready low throughout; word emitted the cycle after fo_full falls, identical value, single strobe.
- Empty finish and ce: code_len=0 with code_finish at fill=0 -> one zero word with last=1, then m_endn; repeat with ce=0 for 3 cycles mid-flush -> output sequence identical, delayed by 3 cycles.
